// File: rtl/decode_pkg.sv
// Shared RV32I decode definitions: opcodes, funct fields, ALU op codes and the
// control bundle carried from the decoder through the output buffer.
package decode_pkg;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  localparam logic [6:0] F7_BASE   = 7'h00;
  localparam logic [6:0] F7_ALT    = 7'h20;
  localparam logic [6:0] F7_MULDIV = 7'h01;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  localparam logic [7:0] ALU_NOP  = 8'h00;
  localparam logic [7:0] ALU_ADD  = 8'h01;
  localparam logic [7:0] ALU_SUB  = 8'h02;
  localparam logic [7:0] ALU_SLL  = 8'h03;
  localparam logic [7:0] ALU_SLT  = 8'h04;
  localparam logic [7:0] ALU_SLTU = 8'h05;
  localparam logic [7:0] ALU_XOR  = 8'h06;
  localparam logic [7:0] ALU_SRL  = 8'h07;
  localparam logic [7:0] ALU_SRA  = 8'h08;
  localparam logic [7:0] ALU_OR   = 8'h09;
  localparam logic [7:0] ALU_AND  = 8'h0a;
  // M-extension codes are contiguous: mul + funct3.
  localparam logic [7:0] ALU_MUL  = 8'h0b;

  // Immediates are formed at instruction width, then sign-extended to XLEN.
  localparam int RAW_IMM_W = 32;

  typedef struct packed {
    logic [4:0] ra1;
    logic [4:0] ra2;
    logic [4:0] wa;
    logic [7:0] aluop;
    logic       re1;
    logic       re2;
    logic       we;
    logic       pce;
    logic       imme;
    logic       jmpe;
    logic       be;
    logic       doe;
    logic       mwe;
    logic [2:0] bop;
    logic [2:0] dmop;
    logic       illegal;
  } decode_ctrl_t;

  function automatic logic [7:0] alu_from_f3(input logic [2:0] f3, input logic alt);
    case (f3)
      F3_ADD:  return alt ? ALU_SUB : ALU_ADD;
      F3_SLL:  return ALU_SLL;
      F3_SLT:  return ALU_SLT;
      F3_SLTU: return ALU_SLTU;
      F3_XOR:  return ALU_XOR;
      F3_SR:   return alt ? ALU_SRA : ALU_SRL;
      F3_OR:   return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/decode_logic.sv
// Combinational RV32I(+M) decoder: raw instruction word to control bundle and
// sign-extended immediate. Anything undecodable becomes an all-zero illegal bundle.
module decode_logic
  import decode_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int ENABLE_M = 0
) (
  input  logic [31:0]     instr_i,
  output decode_ctrl_t    ctrl_o,
  output logic [XLEN-1:0] imm_o
);

  logic [6:0] opcode;
  logic [6:0] funct7;
  logic [2:0] funct3;
  logic [4:0] rs1, rs2, rd;
  logic [RAW_IMM_W-1:0] imm_i, imm_s, imm_b, imm_u, imm_j, shamt;

  assign opcode = instr_i[6:0];
  assign rd     = instr_i[11:7];
  assign funct3 = instr_i[14:12];
  assign rs1    = instr_i[19:15];
  assign rs2    = instr_i[24:20];
  assign funct7 = instr_i[31:25];

  assign imm_i = {{20{instr_i[31]}}, instr_i[31:20]};
  assign imm_s = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
  assign imm_b = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
  assign imm_u = {instr_i[31:12], 12'b0};
  assign imm_j = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0};
  assign shamt = {27'b0, instr_i[24:20]};

  decode_ctrl_t         ctrl;
  logic [RAW_IMM_W-1:0] imm_raw;
  logic                 legal;

  always_comb begin
    ctrl    = '0;
    imm_raw = '0;
    legal   = 1'b0;
    if (instr_i[1:0] == 2'b11) begin
      case (opcode)
        OP_REG: begin
          ctrl.re1 = 1'b1; ctrl.re2 = 1'b1; ctrl.we = 1'b1;
          ctrl.ra1 = rs1;  ctrl.ra2 = rs2;  ctrl.wa = rd;
          if (funct7 == F7_BASE) begin
            legal      = 1'b1;
            ctrl.aluop = alu_from_f3(funct3, 1'b0);
          end else if (funct7 == F7_ALT && (funct3 == F3_ADD || funct3 == F3_SR)) begin
            legal      = 1'b1;
            ctrl.aluop = alu_from_f3(funct3, 1'b1);
          end else if (funct7 == F7_MULDIV && ENABLE_M != 0) begin
            legal      = 1'b1;
            ctrl.aluop = ALU_MUL + 8'(funct3);
          end
        end
        OP_IMM: begin
          ctrl.re1 = 1'b1; ctrl.we = 1'b1; ctrl.imme = 1'b1;
          ctrl.ra1 = rs1;  ctrl.wa = rd;
          ctrl.aluop = alu_from_f3(funct3, funct7 == F7_ALT);
          case (funct3)
            F3_SLL: begin legal = (funct7 == F7_BASE); imm_raw = shamt; end
            F3_SR: begin
              legal   = (funct7 == F7_BASE) || (funct7 == F7_ALT);
              imm_raw = shamt;
            end
            default: begin
              legal      = 1'b1;
              imm_raw    = imm_i;
              ctrl.aluop = alu_from_f3(funct3, 1'b0);
            end
          endcase
        end
        OP_LUI: begin
          // Executed as x0 + imm so the ALU path is shared with AUIPC.
          legal = 1'b1; ctrl.re1 = 1'b1; ctrl.we = 1'b1; ctrl.imme = 1'b1;
          ctrl.wa = rd; ctrl.aluop = ALU_ADD; imm_raw = imm_u;
        end
        OP_AUIPC: begin
          legal = 1'b1; ctrl.pce = 1'b1; ctrl.we = 1'b1; ctrl.imme = 1'b1;
          ctrl.wa = rd; ctrl.aluop = ALU_ADD; imm_raw = imm_u;
        end
        OP_JAL: begin
          legal = 1'b1; ctrl.pce = 1'b1; ctrl.jmpe = 1'b1; ctrl.imme = 1'b1;
          ctrl.we = 1'b1; ctrl.wa = rd; ctrl.aluop = ALU_ADD; imm_raw = imm_j;
        end
        OP_JALR: begin
          legal = (funct3 == 3'b000); ctrl.re1 = 1'b1; ctrl.ra1 = rs1;
          ctrl.jmpe = 1'b1; ctrl.imme = 1'b1; ctrl.we = 1'b1; ctrl.wa = rd;
          ctrl.aluop = ALU_ADD; imm_raw = imm_i;
        end
        OP_BRANCH: begin
          legal = (funct3 != 3'b010) && (funct3 != 3'b011);
          ctrl.re1 = 1'b1; ctrl.re2 = 1'b1; ctrl.ra1 = rs1; ctrl.ra2 = rs2;
          ctrl.be = 1'b1; ctrl.bop = funct3; ctrl.pce = 1'b1; ctrl.imme = 1'b1;
          ctrl.aluop = ALU_ADD; imm_raw = imm_b;
        end
        OP_LOAD: begin
          legal = (funct3 != 3'b011) && (funct3 != 3'b110) && (funct3 != 3'b111);
          ctrl.re1 = 1'b1; ctrl.ra1 = rs1; ctrl.we = 1'b1; ctrl.wa = rd;
          ctrl.doe = 1'b1; ctrl.dmop = funct3; ctrl.imme = 1'b1;
          ctrl.aluop = ALU_ADD; imm_raw = imm_i;
        end
        OP_STORE: begin
          legal = (funct3 <= 3'b010);
          ctrl.re1 = 1'b1; ctrl.re2 = 1'b1; ctrl.ra1 = rs1; ctrl.ra2 = rs2;
          ctrl.mwe = 1'b1; ctrl.dmop = funct3; ctrl.imme = 1'b1;
          ctrl.aluop = ALU_ADD; imm_raw = imm_s;
        end
        default: ;
      endcase
    end
    if (!legal) begin
      ctrl         = '0;
      ctrl.illegal = 1'b1;
      imm_raw      = '0;
    end
  end

  assign ctrl_o = ctrl;
  assign imm_o  = XLEN'($signed(imm_raw));

endmodule

// File: rtl/decode_stage.sv
// Registered decode stage: decodes on entry and holds up to DEPTH bundles in a
// small FIFO so in_ready depends only on registered occupancy.
module decode_stage
  import decode_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int ENABLE_M = 0,
  parameter int DEPTH    = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [4:0]      out_ra1,
  output logic [4:0]      out_ra2,
  output logic [4:0]      out_wa,
  output logic [XLEN-1:0] out_imm,
  output logic [7:0]      out_aluop,
  output logic            out_re1,
  output logic            out_re2,
  output logic            out_we,
  output logic            out_pce,
  output logic            out_imme,
  output logic            out_jmpe,
  output logic            out_be,
  output logic            out_doe,
  output logic            out_mwe,
  output logic [2:0]      out_bop,
  output logic [2:0]      out_dmop,
  output logic            out_illegal
);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] imm;
    decode_ctrl_t    ctrl;
  } entry_t;

  decode_ctrl_t    dec_ctrl;
  logic [XLEN-1:0] dec_imm;

  decode_logic #(
    .XLEN     (XLEN),
    .ENABLE_M (ENABLE_M)
  ) u_decode (
    .instr_i (in_instr),
    .ctrl_o  (dec_ctrl),
    .imm_o   (dec_imm)
  );

  entry_t     mem_q [DEPTH];
  entry_t     head;
  logic [1:0] count_q, count_d;
  logic       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic       push, pop;

  function automatic logic ptr_inc(input logic p);
    return (DEPTH > 1) ? ~p : 1'b0;
  endfunction

  assign in_ready  = !rst && (count_q < 2'(DEPTH));
  assign out_valid = (count_q != 2'd0);
  assign push      = in_valid && in_ready && !flush;
  assign pop       = out_valid && out_ready && !flush;

  always_comb begin
    wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    count_d  = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
    if (flush) begin
      count_d  = 2'd0;
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q  <= 2'd0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
    end else begin
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset: the output view below is masked while empty.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= '{pc: in_pc, imm: dec_imm, ctrl: dec_ctrl};
  end

  always_comb begin
    head = '0;
    if (out_valid) head = mem_q[rd_ptr_q];
  end

  assign out_pc      = head.pc;
  assign out_imm     = head.imm;
  assign out_ra1     = head.ctrl.ra1;
  assign out_ra2     = head.ctrl.ra2;
  assign out_wa      = head.ctrl.wa;
  assign out_aluop   = head.ctrl.aluop;
  assign out_re1     = head.ctrl.re1;
  assign out_re2     = head.ctrl.re2;
  assign out_we      = head.ctrl.we;
  assign out_pce     = head.ctrl.pce;
  assign out_imme    = head.ctrl.imme;
  assign out_jmpe    = head.ctrl.jmpe;
  assign out_be      = head.ctrl.be;
  assign out_doe     = head.ctrl.doe;
  assign out_mwe     = head.ctrl.mwe;
  assign out_bop     = head.ctrl.bop;
  assign out_dmop    = head.ctrl.dmop;
  assign out_illegal = head.ctrl.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench: a 32-bit base-ISA stage and a 64-bit M-enabled stage share stimulus.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, out_ready;
  logic [31:0] in_instr, in_pc32;
  logic [63:0] in_pc64;
  int          checks = 0;
  int          failures = 0;

  assign in_pc64 = {32'h0, in_pc32};
  always #5 clk = ~clk;

  logic        a_in_ready, a_out_valid, a_re1, a_re2, a_we, a_pce, a_imme, a_jmpe, a_be, a_doe, a_mwe, a_ill;
  logic [31:0] a_pc, a_imm;
  logic [4:0]  a_ra1, a_ra2, a_wa;
  logic [7:0]  a_aluop;
  logic [2:0]  a_bop, a_dmop;

  logic        b_in_ready, b_out_valid, b_re1, b_re2, b_we, b_pce, b_imme, b_jmpe, b_be, b_doe, b_mwe, b_ill;
  logic [63:0] b_pc, b_imm;
  logic [4:0]  b_ra1, b_ra2, b_wa;
  logic [7:0]  b_aluop;
  logic [2:0]  b_bop, b_dmop;

  decode_stage #(.XLEN(32), .ENABLE_M(0), .DEPTH(2)) dut32 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(a_in_ready),
    .in_instr(in_instr), .in_pc(in_pc32), .out_valid(a_out_valid), .out_ready(out_ready),
    .out_pc(a_pc), .out_ra1(a_ra1), .out_ra2(a_ra2), .out_wa(a_wa), .out_imm(a_imm),
    .out_aluop(a_aluop), .out_re1(a_re1), .out_re2(a_re2), .out_we(a_we), .out_pce(a_pce),
    .out_imme(a_imme), .out_jmpe(a_jmpe), .out_be(a_be), .out_doe(a_doe), .out_mwe(a_mwe),
    .out_bop(a_bop), .out_dmop(a_dmop), .out_illegal(a_ill)
  );

  decode_stage #(.XLEN(64), .ENABLE_M(1), .DEPTH(2)) dut64 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(b_in_ready),
    .in_instr(in_instr), .in_pc(in_pc64), .out_valid(b_out_valid), .out_ready(out_ready),
    .out_pc(b_pc), .out_ra1(b_ra1), .out_ra2(b_ra2), .out_wa(b_wa), .out_imm(b_imm),
    .out_aluop(b_aluop), .out_re1(b_re1), .out_re2(b_re2), .out_we(b_we), .out_pce(b_pce),
    .out_imme(b_imme), .out_jmpe(b_jmpe), .out_be(b_be), .out_doe(b_doe), .out_mwe(b_mwe),
    .out_bop(b_bop), .out_dmop(b_dmop), .out_illegal(b_ill)
  );

  // Offer one instruction, return on the following falling edge with it at the output.
  task automatic send(input logic [31:0] instr, input logic [31:0] pc);
    @(negedge clk);
    in_instr = instr; in_pc32 = pc; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_instr = '0; in_pc32 = '0;
    repeat (2) @(negedge clk);
    checks++; if (a_in_ready !== 1'b0) begin failures++; $display("FAIL rst_in_ready got=%0b exp=0", a_in_ready); end
    checks++; if (a_out_valid !== 1'b0) begin failures++; $display("FAIL rst_out_valid got=%0b exp=0", a_out_valid); end
    rst = 1'b0;
    @(negedge clk);
    checks++; if (a_in_ready !== 1'b1) begin failures++; $display("FAIL post_rst_in_ready got=%0b exp=1", a_in_ready); end
    checks++; if ({a_out_valid, a_pc, a_imm, a_aluop, a_we} !== '0) begin failures++; $display("FAIL post_rst_payload got=%0h exp=0", {a_out_valid, a_pc, a_imm, a_aluop, a_we}); end
    checks++; if (b_imm !== 64'h0) begin failures++; $display("FAIL post_rst_imm64 got=%0h exp=0", b_imm); end
  endtask

  task automatic test_add;
    send(32'h002081B3, 32'h100);
    checks++; if (a_out_valid !== 1'b1) begin failures++; $display("FAIL add_valid got=%0b exp=1", a_out_valid); end
    checks++; if ({a_ra1, a_ra2, a_wa} !== {5'd1, 5'd2, 5'd3}) begin failures++; $display("FAIL add_regs got=%0d,%0d,%0d exp=1,2,3", a_ra1, a_ra2, a_wa); end
    checks++; if (a_aluop !== 8'h01) begin failures++; $display("FAIL add_aluop got=%0h exp=1", a_aluop); end
    checks++; if ({a_we, a_re1, a_re2, a_imme, a_ill} !== 5'b11100) begin failures++; $display("FAIL add_ctrl got=%b exp=11100", {a_we, a_re1, a_re2, a_imme, a_ill}); end
    checks++; if (a_pc !== 32'h100) begin failures++; $display("FAIL add_pc got=%0h exp=100", a_pc); end
    @(negedge clk);
    checks++; if (a_out_valid !== 1'b0) begin failures++; $display("FAIL add_drained got=%0b exp=0", a_out_valid); end
  endtask

  task automatic test_imm;
    send(32'hFFF00093, 32'h110);
    checks++; if (a_imm !== 32'hFFFFFFFF) begin failures++; $display("FAIL addi_imm32 got=%0h exp=ffffffff", a_imm); end
    checks++; if (b_imm !== 64'hFFFFFFFFFFFFFFFF) begin failures++; $display("FAIL addi_imm64 got=%0h exp=ffffffffffffffff", b_imm); end
    checks++; if ({a_aluop, a_imme, a_wa, a_ra1} !== {8'h01, 1'b1, 5'd1, 5'd0}) begin failures++; $display("FAIL addi_ctrl got=%0h exp=%0h", {a_aluop, a_imme, a_wa, a_ra1}, {8'h01, 1'b1, 5'd1, 5'd0}); end
    send(32'h008000EF, 32'h114);
    checks++; if (a_imm !== 32'd8 || b_imm !== 64'd8) begin failures++; $display("FAIL jal_imm got=%0h/%0h exp=8", a_imm, b_imm); end
    checks++; if ({a_pce, a_jmpe, a_we, a_wa} !== {1'b1, 1'b1, 1'b1, 5'd1}) begin failures++; $display("FAIL jal_ctrl got=%b exp=11100001", {a_pce, a_jmpe, a_we, a_wa}); end
    send(32'h800000B7, 32'h118);
    checks++; if (b_imm !== 64'hFFFFFFFF80000000) begin failures++; $display("FAIL lui_imm64 got=%0h exp=ffffffff80000000", b_imm); end
    checks++; if ({a_re1, a_ra1, a_aluop, a_wa} !== {1'b1, 5'd0, 8'h01, 5'd1}) begin failures++; $display("FAIL lui_ctrl got=%0h exp=%0h", {a_re1, a_ra1, a_aluop, a_wa}, {1'b1, 5'd0, 8'h01, 5'd1}); end
    send(32'h0020A223, 32'h11C);
    checks++; if ({a_wa, a_mwe, a_re2, a_ra2, a_dmop} !== {5'd0, 1'b1, 1'b1, 5'd2, 3'd2}) begin failures++; $display("FAIL sw_ctrl got=%0h exp=%0h", {a_wa, a_mwe, a_re2, a_ra2, a_dmop}, {5'd0, 1'b1, 1'b1, 5'd2, 3'd2}); end
    checks++; if (a_imm !== 32'd4) begin failures++; $display("FAIL sw_imm got=%0h exp=4", a_imm); end
  endtask

  task automatic test_decode_table;
    logic [31:0] instr [14];
    logic [7:0]  op_a [14];
    logic [7:0]  op_b [14];
    logic        ill_a [14];
    logic        ill_b [14];
    instr = '{32'h002081B3, 32'h402081B3, 32'h402090B3, 32'h027302B3, 32'h0000007F, 32'h002081B0, 32'h00002063,
              32'h4010D093, 32'h40109093, 32'h0000B083, 32'h0000C083, 32'h00001067, 32'h0220C2B3, 32'h0020B023};
    op_a  = '{8'h01, 8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h08, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00};
    op_b  = '{8'h01, 8'h02, 8'h00, 8'h0b, 8'h00, 8'h00, 8'h00, 8'h08, 8'h00, 8'h00, 8'h01, 8'h00, 8'h0f, 8'h00};
    ill_a = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    ill_b = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 14; i++) begin
      send(instr[i], 32'h200 + 32'(i * 4));
      checks++;
      if (a_out_valid !== 1'b1 || a_ill !== ill_a[i] || a_aluop !== op_a[i] || a_we !== !ill_a[i]) begin
        failures++;
        $display("FAIL dec32_%08h got=v%0b ill%0b op%0h we%0b exp=v1 ill%0b op%0h we%0b",
                 instr[i], a_out_valid, a_ill, a_aluop, a_we, ill_a[i], op_a[i], !ill_a[i]);
      end
      checks++;
      if (b_out_valid !== 1'b1 || b_ill !== ill_b[i] || b_aluop !== op_b[i] || b_we !== !ill_b[i]) begin
        failures++;
        $display("FAIL dec64_%08h got=v%0b ill%0b op%0h we%0b exp=v1 ill%0b op%0h we%0b",
                 instr[i], b_out_valid, b_ill, b_aluop, b_we, ill_b[i], op_b[i], !ill_b[i]);
      end
    end
  endtask

  task automatic test_backpressure;
    logic [31:0] got [$];
    logic        rec, acc;
    logic [31:0] rec_pc;
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1; in_instr = 32'h00100093; in_pc32 = 32'h300;
    checks++; if (a_in_ready !== 1'b1) begin failures++; $display("FAIL bp_ready0 got=%0b exp=1", a_in_ready); end
    @(negedge clk);
    in_instr = 32'h00200113; in_pc32 = 32'h304;
    checks++; if (a_in_ready !== 1'b1 || a_out_valid !== 1'b1 || a_pc !== 32'h300) begin failures++; $display("FAIL bp_second got=r%0b v%0b pc%0h exp=r1 v1 pc300", a_in_ready, a_out_valid, a_pc); end
    @(negedge clk);
    in_instr = 32'h00300193; in_pc32 = 32'h308;
    checks++; if (a_in_ready !== 1'b0 || a_pc !== 32'h300) begin failures++; $display("FAIL bp_full got=r%0b pc%0h exp=r0 pc300", a_in_ready, a_pc); end
    out_ready = 1'b1;
    for (int i = 0; i < 10 && got.size() < 3; i++) begin
      rec = a_out_valid; rec_pc = a_pc; acc = in_valid && a_in_ready;
      @(negedge clk);
      if (rec) got.push_back(rec_pc);
      if (acc) in_valid = 1'b0;
    end
    in_valid = 1'b0;
    checks++; if (got.size() !== 3) begin failures++; $display("FAIL bp_count got=%0d exp=3", got.size()); end
    for (int k = 0; k < 3 && k < got.size(); k++) begin
      checks++; if (got[k] !== 32'h300 + 32'(k * 4)) begin failures++; $display("FAIL bp_order%0d got=%0h exp=%0h", k, got[k], 32'h300 + 32'(k * 4)); end
    end
    @(negedge clk);
    checks++; if (a_out_valid !== 1'b0) begin failures++; $display("FAIL bp_no_dup got=%0b exp=0", a_out_valid); end
  endtask

  task automatic test_flush;
    logic seen;
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1; in_instr = 32'h00100093; in_pc32 = 32'h400;
    @(negedge clk);
    in_pc32 = 32'h404;
    @(negedge clk);
    flush = 1'b1; in_pc32 = 32'h408;
    @(negedge clk);
    checks++; if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1) begin failures++; $display("FAIL flush_full got=v%0b r%0b exp=v0 r1", a_out_valid, a_in_ready); end
    in_pc32 = 32'h40C;
    @(negedge clk);
    checks++; if (a_out_valid !== 1'b0) begin failures++; $display("FAIL flush_incoming got=%0b exp=0", a_out_valid); end
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    seen = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (a_out_valid) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0) begin failures++; $display("FAIL flush_leak got=%0b exp=0", seen); end
  endtask

  task automatic test_reset_mid;
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1; in_instr = 32'hFFF00093; in_pc32 = 32'h500;
    @(negedge clk);
    in_valid = 1'b0;
    checks++; if (a_out_valid !== 1'b1) begin failures++; $display("FAIL rmid_loaded got=%0b exp=1", a_out_valid); end
    rst = 1'b1;
    @(negedge clk);
    checks++; if (a_in_ready !== 1'b0) begin failures++; $display("FAIL rmid_in_ready got=%0b exp=0", a_in_ready); end
    checks++; if ({a_out_valid, a_pc, a_imm, a_wa, a_we, a_aluop, a_imme} !== '0 || b_imm !== 64'h0) begin failures++; $display("FAIL rmid_payload got=%0h/%0h exp=0", {a_out_valid, a_pc, a_imm, a_wa, a_we, a_aluop, a_imme}, b_imm); end
    rst = 1'b0;
    @(negedge clk);
    checks++; if (a_in_ready !== 1'b1 || a_out_valid !== 1'b0) begin failures++; $display("FAIL rmid_after got=r%0b v%0b exp=r1 v0", a_in_ready, a_out_valid); end
  endtask

  task automatic test_back_to_back;
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i > 0) begin
        checks++;
        if (a_out_valid !== 1'b1 || a_pc !== 32'h600 + 32'((i - 1) * 4)) begin
          failures++;
          $display("FAIL b2b_%0d got=v%0b pc%0h exp=v1 pc%0h", i, a_out_valid, a_pc, 32'h600 + 32'((i - 1) * 4));
        end
      end
      if (i < 4) begin
        checks++; if (a_in_ready !== 1'b1) begin failures++; $display("FAIL b2b_ready%0d got=%0b exp=1", i, a_in_ready); end
        in_valid = 1'b1; in_instr = 32'h002081B3; in_pc32 = 32'h600 + 32'(i * 4);
      end else begin
        in_valid = 1'b0;
      end
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_imm();
    test_decode_table();
    test_backpressure();
    test_flush();
    test_reset_mid();
    test_back_to_back();
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
